uart_bytes_tx: RTL and testbench
================================

// Module: uart_bytes_tx
// PURPOSE
//   Multi-byte UART transmitter, the companion stage to uart_bytes_rx.
//   Accepts one BYTES*8-bit word per handshake and serialises it as BYTES
//   back-to-back 8N1 frames on uart_txd.
//   Byte order and packing are the inverse of uart_bytes_rx, so tx->rx
//   loopback returns the identical word.
// PARAMETERS
//   BYTES    5           bytes sent per accepted word (>=1)
//   BPS      230400      baud rate, bit/s
//   CLK_FRE  50_000_000  sys_clk frequency, Hz
//   BPS_CNT  (local) CLK_FRE/BPS, integer-truncated; 217 for the defaults;
//            must be >=4, otherwise elaboration fails ($error)
// PORTS
//   sys_clk          in   1          system clock; all logic on its rising edge
//   sys_rst_n        in   1          asynchronous reset, active-low
//   uart_bytes_data  in   BYTES*8    word to send; sampled only on accept
//   uart_bytes_vld   in   1          request; accepted when high and busy=0
//   uart_bytes_busy  out  1          high while a word is being transmitted
//   uart_bytes_done  out  1          1-cycle pulse after the last stop bit
//   uart_txd         out  1          UART serial line, idle high, registered
// BEHAVIOUR
//   Reset (sys_rst_n=0, asynchronous): uart_txd=1, busy=0, done=0; FSM to
//     IDLE; all counters and the shift register cleared. Reset mid-word
//     aborts the word immediately and gives no done pulse.
//   FSM: IDLE -> START -> DATA -> STOP -> (START of next byte | IDLE)
//   Accept: in cycle N, vld=1 and busy=0 latch uart_bytes_data into the
//     shift register. In N+1: busy=1, txd=0 (start bit), state START.
//   Bit timing: every bit holds exactly BPS_CNT cycles, timed by baud_cnt
//     running 0..BPS_CNT-1. Bit changes only when baud_cnt wraps.
//   Byte order: data[BYTES*8-1 -: 8] is sent first and data[7:0] last.
//     Within each byte the LSB is sent first.
//   Frame: start(0), d0..d7, stop(1). bit_cnt counts 0..7 in DATA.
//     byte_cnt counts 0..BYTES-1. No idle gap between the bytes of a word.
//   STOP end with byte_cnt<BYTES-1: go to START of the next byte.
//   STOP end with byte_cnt=BYTES-1: go to IDLE. In that next cycle
//     (N+1+BYTES*10*BPS_CNT): busy=0, done=1 for exactly one cycle, txd=1.
//   Total busy length: exactly BYTES*10*BPS_CNT cycles.
//   vld while busy=1: ignored entirely. It is not queued, and the input
//     data may change freely without affecting the line.
//   vld=1 in the done cycle: accepted, because busy is already 0. The line
//     therefore shows a minimum 1-cycle idle high between words.
//   vld held high continuously: words are sent back-to-back, each separated
//     by one idle cycle.
//   Counter widths: baud_cnt is $clog2(BPS_CNT) bits, byte_cnt is
//     $clog2(BYTES)+1 bits. No counter overflows.
// TESTING (BYTES=5, BPS=230400, CLK_FRE=50M, BPS_CNT=217)
//   1 Reset held 100ns, no vld -> txd=1, busy=0, done=0 throughout; reset
//     released -> line stays idle high.
//   2 vld 1 cycle with data=40'h11_22_33_44_55 -> first byte on the line is
//     0,1,0,0,0,1,0,0,0,1 (0x11, LSB first), last is 0x55;
//     busy=1 for 10850 cycles; done pulses once at accept+10851.
//   3 During test 2, vld=1 at byte 2 with data=40'hFF_FF_FF_FF_FF -> line
//     bits identical to test 2; exactly one done pulse.
//   4 vld held high with data constant 40'hA5_5A_00_FF_C3 -> repeated words;
//     start bit exactly 1 cycle after each done; no frame corruption.
//   5 sys_rst_n low mid-byte-3 -> txd=1 in the same sim time step, busy=0,
//     no done. Next vld after release sends a complete fresh word.
//   6 Loopback into uart_bytes_rx (same params), 10 random 40-bit words ->
//     uart_bytes_vld pulses 10 times; each uart_bytes_data equals the word sent.

Source files
------------

// File: rtl/uart_bytes_tx.sv
// Multi-byte 8N1 UART transmitter: one BYTES*8-bit word per handshake, sent
// most-significant byte first, each byte LSB first, with no gap between bytes.
module uart_bytes_tx #(
    parameter int BYTES   = 5,
    parameter int BPS     = 230400,
    parameter int CLK_FRE = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [BYTES*8-1:0] uart_bytes_data,
    input  logic               uart_bytes_vld,
    output logic               uart_bytes_busy,
    output logic               uart_bytes_done,
    output logic               uart_txd
);
    localparam int W       = BYTES * 8;
    localparam int BPS_CNT = CLK_FRE / BPS;
    localparam int BAUD_W  = $clog2(BPS_CNT);
    localparam int BYTE_W  = $clog2(BYTES) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    if (BPS_CNT < 4) begin : g_bps_check
        $error("uart_bytes_tx: CLK_FRE/BPS must be at least 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [W-1:0]        shift_q, shift_d;
    logic                txd_q, txd_d;
    logic                done_q, done_d;

    logic                baud_wrap;
    logic [2:0]          bit_nxt;
    logic [7:0]          cur_byte;

    // The byte on the line is always the top byte; the register shifts up by a byte per frame.
    assign cur_byte  = shift_q[W-1 -: 8];
    assign baud_wrap = (baud_cnt_q == BAUD_LAST);
    assign bit_nxt   = bit_cnt_q + 3'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        done_d     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BAUD_W'(1);
        end

        // txd_d always carries the level of the bit that starts next cycle.
        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                txd_d      = 1'b1;
                if (uart_bytes_vld) begin
                    shift_d = uart_bytes_data;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    txd_d     = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_nxt;
                        txd_d     = cur_byte[bit_nxt];
                    end
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        shift_d    = shift_q << 8;
                        state_d    = S_START;
                        txd_d      = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign uart_bytes_busy = (state_q != S_IDLE);
    assign uart_bytes_done = done_q;
    assign uart_txd        = txd_q;
endmodule

// File: tb/tb_uart_bytes_tx.sv
// Bench for uart_bytes_tx: a default-rate instance (217 clocks/bit) and a
// fast instance (25 clocks/bit) share stimulus; the line is checked against
// a per-bit frame model and decoded by a mid-bit sampling receiver.
module tb_uart_bytes_tx;
  localparam int BYTES    = 5;
  localparam int CNT_SLOW = 50_000_000 / 230400;
  localparam int CNT_FAST = 50_000_000 / 2_000_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] data = '0;
  logic        vld = 1'b0;
  logic        use_slow = 1'b1;
  int          bpc = CNT_SLOW;

  logic busy_s, done_s, txd_s, busy_f, done_f, txd_f;
  logic busy, done, txd;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_bytes_tx u_slow (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_bytes_data(data),
    .uart_bytes_vld(vld && use_slow), .uart_bytes_busy(busy_s),
    .uart_bytes_done(done_s), .uart_txd(txd_s)
  );

  uart_bytes_tx #(.BYTES(5), .BPS(2_000_000), .CLK_FRE(50_000_000)) u_fast (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_bytes_data(data),
    .uart_bytes_vld(vld && !use_slow), .uart_bytes_busy(busy_f),
    .uart_bytes_done(done_f), .uart_txd(txd_f)
  );

  assign busy = use_slow ? busy_s : busy_f;
  assign done = use_slow ? done_s : done_f;
  assign txd  = use_slow ? txd_s : txd_f;

  typedef struct {
    logic [39:0] word;
    logic [7:0]  first;
    logic [7:0]  last;
    bit          slow;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level during bit k of a word: start 0, data LSB first, stop 1, top byte first.
  function automatic logic exp_bit(input logic [39:0] d, input int k);
    int b, p;
    b = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return d[(BYTES - 1 - b) * 8 + p - 1];
  endfunction

  task automatic select(input bit slow);
    use_slow = slow;
    bpc = slow ? CNT_SLOW : CNT_FAST;
  endtask

  task automatic pulse(input logic [39:0] d);
    data = d;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  // Entered at the negedge of the first busy cycle; returns at the done cycle.
  task automatic check_word(input logic [39:0] d, input int inj, input int drop,
                            output logic [39:0] got);
    int total, line_err, busy_err, done_err, frame_err;
    logic rx[50];
    logic [7:0] b8;
    total = BYTES * 10 * bpc;
    line_err = 0; busy_err = 0; done_err = 0; frame_err = 0;
    for (int c = 0; c < total; c++) begin
      if (txd !== exp_bit(d, c / bpc)) line_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
      if (c % bpc == bpc / 2) rx[c / bpc] = txd;
      if (c == inj) begin data = 40'hFF_FF_FF_FF_FF; vld = 1'b1; end
      if (inj >= 0 && c == inj + 5) vld = 1'b0;
      if (c == drop) vld = 1'b0;
      @(negedge clk);
    end
    chk("line_bits_mismatch_cycles", line_err, 0);
    chk("busy_low_cycles", busy_err, 0);
    chk("early_done_cycles", done_err, 0);
    chk("done_cycle_busy_done_txd", {busy, done, txd}, 3'b011);
    got = '0;
    for (int b = 0; b < BYTES; b++) begin
      for (int i = 0; i < 8; i++) b8[i] = rx[b * 10 + 1 + i];
      if (rx[b * 10] !== 1'b0 || rx[b * 10 + 9] !== 1'b1) frame_err++;
      got = {got[31:0], b8};
    end
    chk("frame_errors", frame_err, 0);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("after_done_busy_done", {busy, done}, 2'b00);
  endtask

  initial begin
    logic [39:0] got, d;
    int bad;

    tbl[0] = '{40'h11_22_33_44_55, 8'h11, 8'h55, 1'b1};
    tbl[1] = '{40'hA5_5A_00_FF_C3, 8'hA5, 8'hC3, 1'b0};
    tbl[2] = '{40'h00_00_00_00_00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{40'hFF_FF_FF_FF_FF, 8'hFF, 8'hFF, 1'b0};
    tbl[4] = '{40'h80_01_02_03_FE, 8'h80, 8'hFE, 1'b0};

    // Reset held 100 ns, then released: both lines idle throughout.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({txd_s, busy_s, done_s, txd_f, busy_f, done_f} !== 6'b100100) bad++;
    end
    chk("reset_idle_cycles", bad, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({txd_s, busy_s, done_s, txd_f, busy_f, done_f} !== 6'b100100) bad++;
    end
    chk("post_reset_idle_cycles", bad, 0);

    foreach (tbl[i]) begin
      select(tbl[i].slow);
      pulse(tbl[i].word);
      check_word(tbl[i].word, -1, -1, got);
      chk("word_decoded", got, tbl[i].word);
      chk("first_byte", got[39:32], tbl[i].first);
      chk("last_byte", got[7:0], tbl[i].last);
      after_done();
    end

    // vld during byte 2 of a slow word is ignored and not queued.
    select(1'b1);
    pulse(40'h11_22_33_44_55);
    check_word(40'h11_22_33_44_55, 2 * 10 * CNT_SLOW + 100, -1, got);
    chk("ignored_vld_word", got, 40'h11_22_33_44_55);
    after_done();
    bad = 0;
    for (int i = 0; i < 2 * CNT_SLOW; i++) begin
      @(negedge clk);
      if ({busy, done, txd} !== 3'b001) bad++;
    end
    chk("no_queued_word_cycles", bad, 0);

    // vld held high: back-to-back words separated by the done cycle.
    select(1'b0);
    data = 40'hA5_5A_00_FF_C3;
    vld = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      check_word(40'hA5_5A_00_FF_C3, -1, (w == 2) ? BYTES * 10 * bpc - 1 : -1, got);
      chk("held_vld_word", got, 40'hA5_5A_00_FF_C3);
      if (w < 2) @(negedge clk);
    end
    after_done();

    // Asynchronous reset in the middle of byte index 2.
    d = {8'($urandom_range(0, 255)), 32'($urandom())};
    pulse(d);
    bad = 0;
    for (int c = 0; c < 2 * 10 * CNT_FAST + 12; c++) begin
      if (txd !== exp_bit(d, c / bpc) || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("pre_reset_line_cycles", bad, 0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_txd_busy_done", {txd, busy, done}, 3'b100);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({txd, busy, done} !== 3'b100) bad++;
    end
    chk("in_reset_idle_cycles", bad, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", {txd, busy, done}, 3'b100);
    d = {8'($urandom_range(0, 255)), 32'($urandom())};
    pulse(d);
    check_word(d, -1, -1, got);
    chk("fresh_word_after_reset", got, d);
    after_done();

    // Random words decoded by the bench's receiver.
    for (int n = 0; n < 10; n++) begin
      d = {8'($urandom_range(0, 255)), 32'($urandom())};
      pulse(d);
      check_word(d, -1, -1, got);
      chk("random_word_loopback", got, d);
      after_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
